// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one iteration per clock.
// Ports: clk, rst (async high), start, bin_in[WIDTH], busy, done, bcd_out[4*DIGITS], neg.
// Optional two's-complement input via macro BIN_TO_BCD_SIGNED_EN (neg tied 0 otherwise).
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int SW = 4*DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [SW-1:0]    sr;
  logic [SW-1:0]    sr_adj;
  logic [SW-1:0]    sr_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] load;

`ifdef BIN_TO_BCD_SIGNED_EN
  logic sgn;
  // Magnitude as WIDTH-bit unsigned: the most negative value maps onto itself.
  assign load = bin_in[WIDTH-1] ? WIDTH'(-bin_in) : bin_in;
`else
  assign load = bin_in;
  assign neg  = 1'b0;
`endif

  // Add 3 to each digit >= 5 independently, then shift the whole register.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[WIDTH+4*d +: 4] >= 4'd5)
        sr_adj[WIDTH+4*d +: 4] = sr[WIDTH+4*d +: 4] + 4'd3;
    end
    sr_nx = sr_adj << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
`ifdef BIN_TO_BCD_SIGNED_EN
      sgn     <= 1'b0;
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= {{(4*DIGITS){1'b0}}, load};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CONV;
`ifdef BIN_TO_BCD_SIGNED_EN
            sgn   <= bin_in[WIDTH-1];
`endif
          end
        end
        CONV: begin
          sr  <= sr_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out <= sr_nx[SW-1:WIDTH];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
`ifdef BIN_TO_BCD_SIGNED_EN
            neg     <= sgn;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
